// File: rtl/nvme_pcie_req_sequencer.sv
// nvme_pcie_req_sequencer
//
// Sits in front of the NVMe host PCIe AXI-Lite master stage. Register
// read/write requests from the NVMe host control logic (doorbells,
// controller registers) are queued in a small FIFO. Each request is sent
// downstream as a one-cycle pcie_write/pcie_read strobe. The block then waits
// for the matching done pulse and returns the result on a valid/ready
// response channel. Only one transaction is outstanding downstream at a time.
//
// Optional build macro: NVME_PCIE_TIMEOUT_EN
//   When defined, a WAIT-state watchdog forces completion after
//   TIMEOUT_CYCLES cycles, with rsp_error=1 and rsp_timeout=1.
//   When undefined, WAIT lasts until the matching done and rsp_timeout is 0.
//
// Ports
//   axi_aclk, axi_areset        clock, synchronous active-high reset
//   req_valid/req_ready         request handshake (req_ready = FIFO not full)
//   req_write/req_addr/req_wdata request type, address and write data
//   rsp_valid/rsp_ready         response handshake
//   rsp_write/rsp_rdata         echoed type, read data (0 for writes)
//   rsp_error/rsp_timeout       bus error or timeout; forced-by-timeout flag
//   req_count                   FIFO occupancy
//   spurious_done               sticky flag for unexpected done pulses
//   pcie_write/waddr/wdata      write strobe and payload to the master
//   pcie_wdone/pcie_werror      write completion and error from the master
//   pcie_read/raddr             read strobe and address to the master
//   pcie_rdone/rdata/rerror     read completion, data and error from the master

module nvme_pcie_req_sequencer #(
  parameter int DEPTH          = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                       axi_aclk,
  input  logic                       axi_areset,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic                       req_write,
  input  logic [31:0]                req_addr,
  input  logic [31:0]                req_wdata,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic                       rsp_write,
  output logic [31:0]                rsp_rdata,
  output logic                       rsp_error,
  output logic                       rsp_timeout,
  output logic [$clog2(DEPTH+1)-1:0] req_count,
  output logic                       spurious_done,
  output logic                       pcie_write,
  output logic [31:0]                pcie_waddr,
  output logic [31:0]                pcie_wdata,
  input  logic                       pcie_wdone,
  input  logic                       pcie_werror,
  output logic                       pcie_read,
  output logic [31:0]                pcie_raddr,
  input  logic [31:0]                pcie_rdata,
  input  logic                       pcie_rdone,
  input  logic                       pcie_rerror
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 1) begin : g_cfg_check
    $error("nvme_pcie_req_sequencer: DEPTH must be a power of 2 >= 2 and TIMEOUT_CYCLES >= 1");
  end

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t        r_state;
  logic          r_fifo_write [DEPTH];
  logic [31:0]   r_fifo_addr  [DEPTH];
  logic [31:0]   r_fifo_wdata [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic          r_req_ready;
  logic          r_pend_write;
  logic          r_spurious;
  logic          r_pcie_write;
  logic          r_pcie_read;
  logic [31:0]   r_pcie_waddr;
  logic [31:0]   r_pcie_wdata;
  logic [31:0]   r_pcie_raddr;
  logic          r_rsp_valid;
  logic          r_rsp_write;
  logic [31:0]   r_rsp_rdata;
  logic          r_rsp_error;

  logic          w_push;
  logic          w_pop;
  logic [CW-1:0] w_count_nxt;
  logic          w_wmatch;
  logic          w_rmatch;

  assign w_push = req_valid && r_req_ready;
  // The head entry leaves the FIFO during the single ISSUE cycle.
  assign w_pop  = (r_state == S_ISSUE);

  assign w_wmatch = (r_state == S_WAIT) &&  r_pend_write && pcie_wdone;
  assign w_rmatch = (r_state == S_WAIT) && !r_pend_write && pcie_rdone;

  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop)
      w_count_nxt = r_count + CW'(1);
    else if (!w_push && w_pop)
      w_count_nxt = r_count - CW'(1);
  end

  // FIFO storage carries no reset; occupancy and pointers qualify it.
  always_ff @(posedge axi_aclk) begin
    if (w_push) begin
      r_fifo_write[r_wptr] <= req_write;
      r_fifo_addr[r_wptr]  <= req_addr;
      r_fifo_wdata[r_wptr] <= req_wdata;
    end
  end

  always_ff @(posedge axi_aclk) begin
    if (axi_areset) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_req_ready <= 1'b1;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      r_count     <= w_count_nxt;
      // Registered from next occupancy; a full FIFO never accepts, even on a pop.
      r_req_ready <= (w_count_nxt != CW'(DEPTH));
    end
  end

`ifdef NVME_PCIE_TIMEOUT_EN
  logic [31:0] r_tcnt;
  logic        r_rsp_timeout;
`endif

  always_ff @(posedge axi_aclk) begin
    if (axi_areset) begin
      r_state       <= S_IDLE;
      r_pend_write  <= 1'b0;
      r_spurious    <= 1'b0;
      r_pcie_write  <= 1'b0;
      r_pcie_read   <= 1'b0;
      r_pcie_waddr  <= '0;
      r_pcie_wdata  <= '0;
      r_pcie_raddr  <= '0;
      r_rsp_valid   <= 1'b0;
      r_rsp_write   <= 1'b0;
      r_rsp_rdata   <= '0;
      r_rsp_error   <= 1'b0;
`ifdef NVME_PCIE_TIMEOUT_EN
      r_tcnt        <= '0;
      r_rsp_timeout <= 1'b0;
`endif
    end else begin
      // Any done that is not the expected completion of the pending transfer.
      if ((pcie_wdone && !w_wmatch) || (pcie_rdone && !w_rmatch))
        r_spurious <= 1'b1;

      case (r_state)
        S_IDLE: begin
          if (r_count != '0) begin
            // Strobe and payload are registered here so they are visible
            // exactly during the ISSUE cycle.
            r_state      <= S_ISSUE;
            r_pend_write <= r_fifo_write[r_rptr];
            if (r_fifo_write[r_rptr]) begin
              r_pcie_write <= 1'b1;
              r_pcie_waddr <= r_fifo_addr[r_rptr];
              r_pcie_wdata <= r_fifo_wdata[r_rptr];
            end else begin
              r_pcie_read  <= 1'b1;
              r_pcie_raddr <= r_fifo_addr[r_rptr];
            end
          end
        end

        S_ISSUE: begin
          r_pcie_write <= 1'b0;
          r_pcie_read  <= 1'b0;
`ifdef NVME_PCIE_TIMEOUT_EN
          r_tcnt       <= '0;
`endif
          r_state      <= S_WAIT;
        end

        S_WAIT: begin
          if (w_wmatch || w_rmatch) begin
            r_state     <= S_RESP;
            r_rsp_valid <= 1'b1;
            r_rsp_write <= r_pend_write;
            r_rsp_rdata <= r_pend_write ? 32'd0 : pcie_rdata;
            r_rsp_error <= r_pend_write ? pcie_werror : pcie_rerror;
`ifdef NVME_PCIE_TIMEOUT_EN
            r_rsp_timeout <= 1'b0;
          end else if (r_tcnt == 32'(TIMEOUT_CYCLES - 1)) begin
            // This is the last allowed WAIT cycle without a matching done.
            r_state       <= S_RESP;
            r_rsp_valid   <= 1'b1;
            r_rsp_write   <= r_pend_write;
            r_rsp_rdata   <= '0;
            r_rsp_error   <= 1'b1;
            r_rsp_timeout <= 1'b1;
          end else begin
            r_tcnt <= r_tcnt + 32'd1;
`endif
          end
        end

        S_RESP: begin
          if (rsp_ready) begin
            r_state     <= S_IDLE;
            r_rsp_valid <= 1'b0;
            r_rsp_write <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_error <= 1'b0;
`ifdef NVME_PCIE_TIMEOUT_EN
            r_rsp_timeout <= 1'b0;
`endif
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_ready     = r_req_ready;
  assign req_count     = r_count;
  assign spurious_done = r_spurious;
  assign pcie_write    = r_pcie_write;
  assign pcie_read     = r_pcie_read;
  assign pcie_waddr    = r_pcie_waddr;
  assign pcie_wdata    = r_pcie_wdata;
  assign pcie_raddr    = r_pcie_raddr;
  assign rsp_valid     = r_rsp_valid;
  assign rsp_write     = r_rsp_write;
  assign rsp_rdata     = r_rsp_rdata;
  assign rsp_error     = r_rsp_error;
`ifdef NVME_PCIE_TIMEOUT_EN
  assign rsp_timeout   = r_rsp_timeout;
`else
  assign rsp_timeout   = 1'b0;
`endif

endmodule

// File: doc/nvme_pcie_req_sequencer.md
Name: nvme_pcie_req_sequencer

Overview:
- Upstream neighbour of the NVMe host PCIe AXI-Lite master stage.
- Queues 32-bit register read/write requests from NVMe host control logic (doorbells, controller registers) in a small FIFO.
- Issues them one at a time as single-cycle pcie_write/pcie_read pulses and waits for the matching done.
- Returns read data and error/timeout status on a valid/ready response channel; exactly one transaction outstanding downstream.

Parameters:
- DEPTH, 4, request FIFO entries; power of 2, at least 2.
- TIMEOUT_CYCLES, 1024, WAIT-state cycle limit before forced completion; only used with NVME_PCIE_TIMEOUT_EN.

Ports:
- axi_aclk  in  1  clock
- axi_areset  in  1  synchronous active-high reset
- req_valid  in  1  request present
- req_ready  out  1  FIFO can accept
- req_write  in  1  1=write, 0=read
- req_addr  in  32  register address
- req_wdata  in  32  write data (ignored for reads)
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed
- rsp_write  out  1  echo of request type
- rsp_rdata  out  32  read data (0 for writes)
- rsp_error  out  1  bus error or timeout
- rsp_timeout  out  1  completion forced by timeout
- req_count  out  $clog2(DEPTH+1)  FIFO occupancy
- spurious_done  out  1  sticky: done seen outside WAIT, or wrong type in WAIT
- pcie_write  out  1  one-cycle write strobe to the master
- pcie_waddr  out  32  write address
- pcie_wdata  out  32  write data
- pcie_wdone  in  1  write complete pulse
- pcie_werror  in  1  write error, qualified by pcie_wdone
- pcie_read  out  1  one-cycle read strobe to the master
- pcie_raddr  out  32  read address
- pcie_rdata  in  32  read data, qualified by pcie_rdone
- pcie_rdone  in  1  read complete pulse
- pcie_rerror  in  1  read error, qualified by pcie_rdone

Behaviour:
- Reset values: all outputs 0 except req_ready=1. FIFO emptied, counters 0, FSM in IDLE.
- Push: req_valid && req_ready.
  - req_ready = !full, registered from occupancy; no full-bypass.
  - Push and pop in the same cycle leaves req_count unchanged.
- FSM states:
  - IDLE: FIFO non-empty -> ISSUE next cycle.
  - ISSUE: exactly one cycle.
    - Drive the head entry onto pcie_waddr/pcie_wdata or pcie_raddr.
    - Assert pcie_write or pcie_read for that cycle only.
    - Pop the FIFO, latch the type, clear the timeout counter, go to WAIT.
  - WAIT:
    - Write pending: pcie_wdone -> rsp_error=pcie_werror, rsp_rdata=0, go to RESP.
    - Read pending: pcie_rdone -> rsp_rdata=pcie_rdata, rsp_error=pcie_rerror, go to RESP.
    - Done of the other type: ignored; sets spurious_done.
  - RESP: rsp_valid=1 with stable rsp_* until rsp_ready; on handshake go to IDLE and clear rsp_*.
- Minimum latency: push at cycle N -> strobe at N+2 (IDLE decision N+1, ISSUE N+2).
- Response appears the cycle after the done pulse.
- pcie_waddr/pcie_wdata/pcie_raddr hold their last values outside ISSUE.
- Done pulse in IDLE/ISSUE/RESP: ignored, sets spurious_done. spurious_done clears only on reset.
- Address/data pass through unmodified at full 32 bits; no alignment check.
- Back-pressure: while in RESP, no new strobe is issued; the FIFO keeps accepting until full.
- Reset mid-operation:
  - Immediate return to IDLE, FIFO flushed, rsp_valid dropped.
  - A downstream done arriving after reset sets spurious_done and is otherwise ignored.

Optional Feature:
- Macro: NVME_PCIE_TIMEOUT_EN.
- Defined:
  - A 32-bit counter increments each WAIT cycle.
  - When it reaches TIMEOUT_CYCLES with no matching done: go to RESP with rsp_error=1, rsp_timeout=1, rsp_rdata=0.
  - A done on the same cycle as expiry wins; normal completion, rsp_timeout=0.
  - Late dones after a timeout set spurious_done.
- Undefined: no counter; WAIT lasts until the matching done; rsp_timeout tied to 0.

Test Plan:
- Push write addr 0x1008, data 0x00000001; hold pcie_wdone low 3 cycles, then pulse it with pcie_werror=0 -> one pcie_write pulse with pcie_waddr=0x1008, pcie_wdata=0x1; then rsp_valid, rsp_write=1, rsp_error=0, rsp_rdata=0.
- Push read addr 0x0000001C; pulse pcie_rdone with pcie_rdata=0xDEADBEEF, pcie_rerror=1 -> rsp_rdata=0xDEADBEEF, rsp_error=1, rsp_write=0.
- Hold rsp_ready=0 and push 5 requests (DEPTH=4) -> req_ready drops with req_count=4 after the head pops; only one strobe issued until the response is accepted; then in-order issue of the rest.
- Pulse pcie_rdone while a write is pending, and pcie_wdone in IDLE -> spurious_done=1 sticky; the write still completes on its own pcie_wdone.
- With NVME_PCIE_TIMEOUT_EN, TIMEOUT_CYCLES=16, read issued and no done -> after 16 WAIT cycles rsp_error=1, rsp_timeout=1; a later pcie_rdone sets spurious_done.
- Assert axi_areset in WAIT with 2 entries queued -> rsp_valid=0, req_count=0, no further strobes; a subsequent pcie_wdone sets spurious_done.
